demux_stream: RTL
=================

Name: demux_stream

Overview:
- Parametrised, registered successor to the 8-way combinational demux.
- Routes one WIDTH-bit word per cycle from a single valid/ready input stream to one of NUM_OUT output channels, chosen by in_sel.
- Each channel has a one-entry output register with its own backpressure, so a stalled channel does not block words bound for other channels.
- Sits between the CPU data path and its peripheral/memory-mapped write ports.

Parameters:
- WIDTH, 16: data word width in bits.
- NUM_OUT, 8: number of output channels; 2..16.
- SEL_W, 3: in_sel width; NUM_OUT <= 2**SEL_W is required and checked at elaboration.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- in_data  in  WIDTH  input word.
- in_sel  in  SEL_W  destination channel index.
- out_valid  out  NUM_OUT  per-channel word present.
- out_ready  in  NUM_OUT  per-channel consumer accepts.
- out_data  out  NUM_OUT*WIDTH  packed channel words; channel i occupies bits [i*WIDTH +: WIDTH].
- sel_err  out  1  one-cycle pulse: a word with out-of-range in_sel was dropped.
- drop_cnt  out  8  saturating count of dropped words.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: out_valid=0, out_data=0, sel_err=0, drop_cnt=0. in_ready is combinational but reads 0 while rst_n=0.
- Channel slot i is free when out_valid[i]=0, or when out_valid[i]=1 and out_ready[i]=1 in the same cycle (pass-through drain).
- in_ready:
  - in_sel < NUM_OUT: in_ready equals free(in_sel).
  - in_sel >= NUM_OUT: in_ready=1.
- in_ready must not depend on in_valid.
- Accept = in_valid & in_ready. On accept with a valid in_sel, slot in_sel loads in_data and sets out_valid at the next edge. Latency is 1 cycle.
- Drain: out_valid[i]&out_ready[i] clears slot i at the next edge, unless that slot reloads in the same cycle. Simultaneous drain and load yields out_valid=1 with the new data.
- out_data[i] holds its value while out_valid[i]=1 and out_ready[i]=0. Data is stable under backpressure.
- Other slots are unaffected by an accept. At most one slot loads per cycle.
- Out-of-range accept (in_sel >= NUM_OUT):
  - The word is dropped and no slot changes.
  - sel_err=1 for exactly the following cycle.
  - drop_cnt increments and saturates at 255.
- When NUM_OUT = 2**SEL_W, the out-of-range path is unreachable. sel_err stays 0 and drop_cnt stays 0.
- in_valid=0: no state change other than drains.
- Reset mid-operation: all pending words are lost, and every output returns to its reset value immediately (asynchronous).

Optional Feature:
- Macro: DEMUX_STREAM_BCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - When in_bcast=1, in_sel is ignored.
  - in_ready = AND of free(i) over all channels.
  - On accept, every slot loads in_data simultaneously.
  - A broadcast is never counted as a drop.
- Undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package demux_pkg:
  - DROP_CNT_W=8 and DROP_CNT_MAX=255.
  - Elaboration-check helper confirming NUM_OUT <= 2**SEL_W.
- Sub-module demux_slot (parameter WIDTH):
  - One-entry valid/ready register with load, drain and free outputs.
  - Instantiated NUM_OUT times via generate.
  - Top level holds select decode, in_ready mux, broadcast logic and error/counter logic.

Test Plan:
- Sweep: in_valid=1, in_data=16'hA5A0+sel, all out_ready=1, in_sel stepping 0..7 per cycle -> out_valid one-hot channel sel one cycle later, out_data[sel]=16'hA5A0+sel, in_ready=1 throughout.
- Backpressure: out_ready[2]=0, send two words to ch2 (16'h1111, 16'h2222) -> first held stable, in_ready=0 for sel=2. A concurrent word to ch5 is accepted and delivered. Release out_ready[2] -> 16'h2222 loads the same cycle ch2 drains.
- Out-of-range: NUM_OUT=6, SEL_W=3, in_sel=7 with in_valid=1 for 3 cycles -> in_ready=1, no out_valid change, sel_err high for 3 consecutive cycles, drop_cnt=3. Force 300 drops -> drop_cnt=255.
- Reset mid-flight: fill ch0, ch3, ch7, then assert rst_n=0 asynchronously between edges -> out_valid=0, drop_cnt=0 immediately. After release, a normal word routes correctly.
- Broadcast (DEMUX_STREAM_BCAST_EN): in_bcast=1, in_data=16'hBEEF with out_ready[4]=0 and slot 4 full -> in_ready=0. Raise out_ready[4] -> all 8 slots show 16'hBEEF next cycle, drop_cnt unchanged.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and configuration check for demux_stream
//   DROP_CNT_W / DROP_CNT_MAX : width and saturation value of the drop counter
//   sel_fits()                : true when NUM_OUT is 2..16 and fits in 2**SEL_W
package demux_pkg;
  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;
  function automatic bit sel_fits(int num_out, int sel_w);
    return num_out >= 2 && num_out <= 16 && num_out <= (1 << sel_w);
  endfunction
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry valid/ready output register for a single channel
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : capture data_i at the next edge (only asserted while free_o)
//   data_i      : word to capture
//   ready_i     : consumer accepts the held word
//   valid_o     : a word is held
//   data_o      : held word, stable while valid_o & ~ready_i
//   free_o      : slot can take a word this cycle (empty or draining now)
module demux_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             free_o
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  assign free_o  = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  always_comb begin
    valid_d = load_i | (valid_q & ~ready_i);
    data_d  = load_i ? data_i : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-NUM_OUT stream demux with per-channel backpressure
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_ready never depends on in_valid
//   in_data, in_sel     : input word and destination channel
//   in_bcast            : (only with DEMUX_STREAM_BCAST_EN) load every channel at once
//   out_valid/out_ready : per-channel handshake
//   out_data            : channel i at bits [i*WIDTH +: WIDTH]
//   sel_err             : one-cycle pulse after an out-of-range word is dropped
//   drop_cnt            : saturating count of dropped words
// Optional feature macro: DEMUX_STREAM_BCAST_EN
module demux_stream
  import demux_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = 8,
  parameter int SEL_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
`ifdef DEMUX_STREAM_BCAST_EN
  input  logic                     in_bcast,
`endif
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic                     sel_err,
  output logic [DROP_CNT_W-1:0]    drop_cnt
);
  localparam int SEL_N = 1 << SEL_W;
  if (!sel_fits(NUM_OUT, SEL_W)) begin : g_bad_cfg
    $error("demux_stream: NUM_OUT must be 2..16 and <= 2**SEL_W");
  end
  logic                  bcast, sel_ok, acc, drop;
  logic [NUM_OUT-1:0]    free, load;
  logic [SEL_N-1:0]      free_ext;
  logic                  sel_err_q, sel_err_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
`ifdef DEMUX_STREAM_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif
  assign sel_ok = 32'(in_sel) < NUM_OUT;
  // Pad the free vector to the full select range so in_sel can index it directly.
  always_comb begin
    free_ext = '0;
    free_ext[NUM_OUT-1:0] = free;
  end
  // Out-of-range selects are always accepted so they can be dropped and counted.
  assign in_ready = rst_n & (bcast ? &free : (sel_ok ? free_ext[in_sel] : 1'b1));
  assign acc      = in_valid & in_ready;
  assign drop     = acc & ~bcast & ~sel_ok;
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    assign load[i] = acc & (bcast | (in_sel == SEL_W'(i)));
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[i]),
      .data_i  (in_data),
      .ready_i (out_ready[i]),
      .valid_o (out_valid[i]),
      .data_o  (out_data[i*WIDTH +: WIDTH]),
      .free_o  (free[i])
    );
  end
  always_comb begin
    sel_err_d  = drop;
    drop_cnt_d = (drop && drop_cnt_q != DROP_CNT_MAX) ? drop_cnt_q + DROP_CNT_W'(1) : drop_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      sel_err_q  <= sel_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign sel_err  = sel_err_q;
  assign drop_cnt = drop_cnt_q;
endmodule
